mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Parametrised line-transfer arbiter between NUM_PORTS L1 caches and the single shared main memory. It replaces the fixed two-source (I/D) line path with round-robin arbitration and whole-line transfers. Fills are optionally critical-word-first with wrap-around; writebacks are sequential. It sits between the L1 cache controllers and the main memory, which has per-word `MM_VALID` handshakes.

## Interface
- `NUM_PORTS`, 2: number of requesting caches (≥2).
- `ADDR_SIZE`, 32: byte-address width.
- `WORD_SIZE`, 32: data word width.
- `WORDS_PER_LINE`, 8: beats per line (power of 2, ≥2). `OFS = log2(WORDS_PER_LINE)`.
- `CRIT_WORD_FIRST`, 1: 1 = fills start at the requested word and wrap; 0 = fills start at word 0.

Ports:
- `MEM_CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `REQ`  in  NUM_PORTS  per-port line request, level.
- `REQ_WE`  in  NUM_PORTS  per port: 1 = writeback, 0 = fill.
- `REQ_ADDR`  in  NUM_PORTS*ADDR_SIZE  per-port byte address; bits [1:0] ignored.
- `WB_DATA`  in  NUM_PORTS*WORD_SIZE  per port: writeback word for the current `BEAT_IDX`.
- `GRANT`  out  NUM_PORTS  one-hot owner, or 0.
- `BEAT_VALID`  out  1  a beat completes this cycle.
- `BEAT_IDX`  out  OFS  word index within the line of the current beat.
- `FILL_DATA`  out  WORD_SIZE  fill word; valid when `BEAT_VALID` is high and the transfer is a fill.
- `DONE`  out  NUM_PORTS  one-cycle pulse to the owner after its last beat.
- `MM_RE`, `MM_WE`  out  1  main memory read / write strobe.
- `MM_ADDR`  out  ADDR_SIZE-2  main memory word address.
- `MM_DIN`  out  WORD_SIZE  write data to main memory.
- `MM_DOUT`  in  WORD_SIZE  read data from main memory.
- `MM_VALID`  in  1  main memory completed the current word.

## Operation
- State machine: IDLE → XFER → FIN → IDLE.
- **IDLE**
  - If any `REQ` is high, select the winner by round-robin: search from `last+1` upward and wrap; `last` resets to NUM_PORTS-1, so port 0 wins first.
  - At the edge, latch winner index, `REQ_WE[w]`, line base `REQ_ADDR[w][ADDR_SIZE-1:OFS+2]`, and start offset.
  - Start offset = `REQ_ADDR[w][OFS+1:2]` for a fill with `CRIT_WORD_FIRST=1`; otherwise 0.
  - Set `beat_cnt=0`, `BEAT_IDX=start`, `last=w`, and go to XFER.
- **XFER**
  - `GRANT` is one-hot on the winner.
  - `MM_RE=~we_l`, `MM_WE=we_l`, `MM_ADDR={base, BEAT_IDX}`.
  - `MM_DIN=WB_DATA[w]` (combinational mux). The requester presents its line word for `BEAT_IDX` combinationally.
  - `BEAT_VALID=MM_VALID`.
  - `FILL_DATA=MM_DOUT` when `BEAT_VALID & ~we_l`, else 0.
  - On `MM_VALID`: `BEAT_IDX` increments modulo WORDS_PER_LINE (wrap 7→0 at the default) and `beat_cnt` increments. Strobes stay high, so back-to-back beats are allowed.
  - On the `MM_VALID` where `beat_cnt == WORDS_PER_LINE-1`: go to FIN, strobes drop.
- **FIN**
  - `DONE[w]=1` for exactly one cycle; `GRANT` stays on the winner.
  - Strobes are 0, `BEAT_VALID=0`.
  - Next state is IDLE.
- `REQ` changes during XFER/FIN are ignored. A transfer always completes all beats once granted.
- A requester drops `REQ` on the edge where it samples `DONE`. IDLE then re-arbitrates on the following cycle.
- A port that keeps `REQ` high is re-granted only when no other port requests, because round-robin has moved past it.
- `MM_VALID` while in IDLE or FIN is ignored.

## Timing
- Reset (`RST_N=0`, asynchronous):
  - State IDLE, `last=NUM_PORTS-1`, `BEAT_IDX=0`, `beat_cnt=0`.
  - Outputs `GRANT`, `DONE`, `MM_RE`, `MM_WE`, `BEAT_VALID` = 0.
  - `MM_ADDR`, `MM_DIN`, `FILL_DATA` = 0.
  - This applies mid-transfer too: the transfer is abandoned, no `DONE` is issued, and the main memory sees its strobes drop immediately.
- `GRANT` and the strobes rise one cycle after `REQ` is sampled high in IDLE.
- Line transfer latency with main memory latency L per word:
  - From the `REQ` sample to `DONE` = 1 + WORDS_PER_LINE·L cycles.
  - Next arbitration one cycle after `DONE`.
- `BEAT_VALID`, `FILL_DATA` and `MM_DIN` are combinational from `MM_VALID`, `MM_DOUT` and `WB_DATA`. All other outputs are registered or decoded from state.
- Simultaneous requests are resolved by round-robin only; no port can be starved beyond NUM_PORTS-1 transfers.

## Test plan
- **Single fill, critical word first.** Port 0 fill at address 0x0000_6014, `CRIT_WORD_FIRST=1`, L=3.
  - `BEAT_IDX` sequence 5,6,7,0,1,2,3,4; `MM_ADDR` 0x1805,0x1806,0x1807,0x1800…0x1804.
  - `DONE[0]` at cycle 25.
- **Critical word first disabled.** Same stimulus with `CRIT_WORD_FIRST=0`.
  - Beats run 0..7; `MM_ADDR` starts at 0x1800.
- **Writeback.** Port 1 writeback at 0x0000_7020, WB word = 0xA000_0000+idx.
  - `MM_WE=1`; `MM_DIN` = 0xA000_0000..0xA000_0007 at `MM_ADDR` 0x1C08..0x1C0F; `DONE[1]` pulses once.
- **Fairness.** Ports 0 and 1 hold `REQ` continuously, NUM_PORTS=2.
  - Grants alternate 0,1,0,1.
  - With NUM_PORTS=4 and all four requesting: 0,1,2,3,0.
- **Reset mid-transfer.** Assert `RST_N=0` mid-transfer after beat 3, then release it.
  - All outputs 0 asynchronously; no `DONE`.
  - After release, a new port 1 request is granted and restarts at its start offset.
- **Stray/back-to-back `MM_VALID`.** Assert `MM_VALID` high every cycle during XFER (L=1), and pulse `MM_VALID` in IDLE.
  - During XFER, 8 consecutive `BEAT_VALID`s.
  - The IDLE pulse changes no state and produces no `BEAT_VALID`.

Source files
------------

// File: rtl/mem_line_arbiter.sv
`timescale 1ns/1ps
// mem_line_arbiter: round-robin whole-line transfer arbiter between
// NUM_PORTS L1 caches and a single shared main memory. Fills may start at
// the critical word and wrap around the line; writebacks are always
// sequential from word 0.
module mem_line_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_SIZE       = 32,
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_LINE  = 8,
  parameter int CRIT_WORD_FIRST = 1,
  localparam int OFS = $clog2(WORDS_PER_LINE),
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int BW  = ADDR_SIZE - 2 - OFS
) (
  input  logic                           MEM_CLK,
  input  logic                           RST_N,
  input  logic [NUM_PORTS-1:0]           REQ,
  input  logic [NUM_PORTS-1:0]           REQ_WE,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] REQ_ADDR,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] WB_DATA,
  output logic [NUM_PORTS-1:0]           GRANT,
  output logic                           BEAT_VALID,
  output logic [OFS-1:0]                 BEAT_IDX,
  output logic [WORD_SIZE-1:0]           FILL_DATA,
  output logic [NUM_PORTS-1:0]           DONE,
  output logic                           MM_RE,
  output logic                           MM_WE,
  output logic [ADDR_SIZE-3:0]           MM_ADDR,
  output logic [WORD_SIZE-1:0]           MM_DIN,
  input  logic [WORD_SIZE-1:0]           MM_DOUT,
  input  logic                           MM_VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  last_q;
  logic [PW-1:0]  win_q;
  logic           we_q;
  logic [BW-1:0]  base_q;
  logic [OFS-1:0] idx_q;
  logic [OFS-1:0] cnt_q;

  logic [ADDR_SIZE-1:0] addr_arr [NUM_PORTS];
  logic [WORD_SIZE-1:0] wb_arr   [NUM_PORTS];

  logic                 rr_any;
  logic [PW-1:0]        rr_win;
  logic [PW-1:0]        cand;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [OFS-1:0]       start_ofs;
  logic                 last_beat;
  logic                 unused_addr_lo;

  // Split the flat per-port request buses into per-port words.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      addr_arr[p] = REQ_ADDR[p*ADDR_SIZE +: ADDR_SIZE];
      wb_arr[p]   = WB_DATA[p*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Round-robin search starting just after the previous winner, wrapping.
  always_comb begin
    rr_any = 1'b0;
    rr_win = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((32'(last_q) + k) % NUM_PORTS);
      if (!rr_any && REQ[cand]) begin
        rr_any = 1'b1;
        rr_win = cand;
      end
    end
  end

  // Winner's address and the word the line transfer starts on.
  always_comb begin
    win_addr  = addr_arr[rr_win];
    start_ofs = '0;
    if (CRIT_WORD_FIRST != 0 && !REQ_WE[rr_win]) begin
      start_ofs = win_addr[OFS+1:2];
    end
  end

  assign unused_addr_lo = ^win_addr[1:0];
  assign last_beat      = (cnt_q == OFS'(WORDS_PER_LINE - 1));

  // State register.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rr_any) state_d = XFER;
      XFER:    if (MM_VALID && last_beat) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer context: latched at grant, beat counters advance per MM_VALID.
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= PW'(NUM_PORTS - 1);
      win_q  <= '0;
      we_q   <= 1'b0;
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            win_q  <= rr_win;
            last_q <= rr_win;
            we_q   <= REQ_WE[rr_win];
            base_q <= win_addr[ADDR_SIZE-1:OFS+2];
            idx_q  <= start_ofs;
            cnt_q  <= '0;
          end
        end
        XFER: begin
          if (MM_VALID) begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BEAT_IDX = idx_q;

  // Output decode; data paths are gated so idle/reset outputs read as zero.
  always_comb begin
    GRANT      = '0;
    DONE       = '0;
    MM_RE      = 1'b0;
    MM_WE      = 1'b0;
    BEAT_VALID = 1'b0;
    MM_ADDR    = '0;
    MM_DIN     = '0;
    FILL_DATA  = '0;
    case (state_q)
      XFER: begin
        GRANT[win_q] = 1'b1;
        MM_RE        = ~we_q;
        MM_WE        = we_q;
        MM_ADDR      = {base_q, idx_q};
        BEAT_VALID   = MM_VALID;
        if (we_q) begin
          MM_DIN = wb_arr[win_q];
        end else if (MM_VALID) begin
          FILL_DATA = MM_DOUT;
        end
      end
      FIN: begin
        GRANT[win_q] = 1'b1;
        DONE[win_q]  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_line_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration and line beats.
module tb_mem_line_arbiter;
  localparam int NP = 4;
  localparam int AS = 32;
  localparam int WS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NP-1:0]    req, req_we, grant, done;
  logic [NP*AS-1:0] req_addr;
  logic [NP*WS-1:0] wb_data;
  logic             beat_valid, mm_re, mm_we, mm_valid;
  logic [2:0]       beat_idx;
  logic [WS-1:0]    fill_data, mm_din, mm_dout;
  logic [29:0]      mm_addr;

  // Second instance: two ports, critical-word-first disabled, L=1 memory.
  logic [1:0]  b_req, b_req_we, b_grant, b_done;
  logic [63:0] b_req_addr, b_wb_data;
  logic        b_beat_valid, b_mm_re, b_mm_we, b_mm_valid;
  logic [2:0]  b_beat_idx;
  logic [31:0] b_fill_data, b_mm_din, b_mm_dout;
  logic [29:0] b_mm_addr;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h3C5A_96E1 ^ {a[7:0], 24'h0};
  endfunction

  function automatic logic [31:0] wb_val(input int p, input logic [2:0] i);
    logic [31:0] b;
    b = (p == 1) ? 32'hA000_0000 : (32'hB000_0000 + (32'(p) << 16));
    return b + 32'(i);
  endfunction

  // Word address of beat k of a line transfer, from the addressing rules.
  function automatic logic [29:0] exp_word(input logic [31:0] a, input logic we,
                                           input bit cwf, input int k);
    int s;
    s = (cwf && !we) ? int'(a[4:2]) : 0;
    return {a[31:5], 3'((s + k) % 8)};
  endfunction

  // Round-robin reference: first requester after 'last', wrapping.
  function automatic int rr(input logic [NP-1:0] r, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (r[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  mem_line_arbiter #(.NUM_PORTS(NP), .ADDR_SIZE(AS), .WORD_SIZE(WS),
                     .WORDS_PER_LINE(8), .CRIT_WORD_FIRST(1)) dut (
    .MEM_CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .WB_DATA(wb_data), .GRANT(grant), .BEAT_VALID(beat_valid), .BEAT_IDX(beat_idx),
    .FILL_DATA(fill_data), .DONE(done), .MM_RE(mm_re), .MM_WE(mm_we),
    .MM_ADDR(mm_addr), .MM_DIN(mm_din), .MM_DOUT(mm_dout), .MM_VALID(mm_valid));

  mem_line_arbiter #(.NUM_PORTS(2), .ADDR_SIZE(32), .WORD_SIZE(32),
                     .WORDS_PER_LINE(8), .CRIT_WORD_FIRST(0)) dut_b (
    .MEM_CLK(clk), .RST_N(rst_n), .REQ(b_req), .REQ_WE(b_req_we), .REQ_ADDR(b_req_addr),
    .WB_DATA(b_wb_data), .GRANT(b_grant), .BEAT_VALID(b_beat_valid), .BEAT_IDX(b_beat_idx),
    .FILL_DATA(b_fill_data), .DONE(b_done), .MM_RE(b_mm_re), .MM_WE(b_mm_we),
    .MM_ADDR(b_mm_addr), .MM_DIN(b_mm_din), .MM_DOUT(b_mm_dout), .MM_VALID(b_mm_valid));

  assign b_mm_valid = b_mm_re | b_mm_we;
  assign b_mm_dout  = mem_val(b_mm_addr);
  assign b_wb_data  = '0;
  assign mm_dout    = mem_val(mm_addr);

  // Each requester presents its line word for the current beat index.
  always_comb begin
    for (int p = 0; p < NP; p++) wb_data[p*WS +: WS] = wb_val(p, beat_idx);
  end

  // Main memory responder: MM_VALID on the lat-th cycle of each strobed word.
  int lat = 1;
  bit stray_en = 1'b0;
  bit force_valid = 1'b0;
  int wcnt = 0;
  initial mm_valid = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mm_re || mm_we) begin
      wcnt++;
      if (wcnt >= lat) begin
        mm_valid = 1'b1;
        wcnt = 0;
      end else begin
        mm_valid = 1'b0;
      end
    end else begin
      wcnt = 0;
      mm_valid = stray_en ? 1'($urandom_range(0, 1)) : force_valid;
    end
  end

  // Capture of one directed transfer.
  logic [2:0]  cap_idx  [16];
  logic [29:0] cap_addr [16];
  logic [31:0] cap_data [16];
  logic        cap_we   [16];
  int          cap_cyc  [16];
  int          n_cap;
  logic [NP-1:0] first_grant, cap_done;

  task automatic reset_dut();
    @(posedge clk); #2;
    stray_en = 1'b0; force_valid = 1'b0;
    rst_n = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Raise one request, record beats until DONE (or budget), then drop REQ.
  task automatic do_xfer(input int port, input logic we, input logic [31:0] addr,
                         output int done_cyc);
    @(posedge clk); #2;
    req_we[port] = we;
    req_addr[port*AS +: AS] = addr;
    req[port] = 1'b1;
    @(posedge clk);
    n_cap = 0; done_cyc = -1; cap_done = '0; first_grant = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) first_grant = grant;
      if (beat_valid && n_cap < 16) begin
        cap_idx[n_cap]  = beat_idx;
        cap_addr[n_cap] = mm_addr;
        cap_data[n_cap] = mm_we ? mm_din : fill_data;
        cap_we[n_cap]   = mm_we;
        cap_cyc[n_cap]  = c;
        n_cap++;
      end
      if (done != '0) begin
        done_cyc = c;
        cap_done = done;
        break;
      end
    end
    @(posedge clk); #2;
    req[port] = 1'b0;
  endtask

  task automatic test_reset();
    req = '1; req_we = 4'b1010; req_addr = {$urandom, $urandom, $urandom, $urandom};
    force_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
    n_tests++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if ({mm_re, mm_we, beat_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {mm_re, mm_we, beat_valid}); end
    n_tests++; if (mm_addr !== '0) begin n_fail++; $display("FAIL reset_mm_addr: got %h want 0", mm_addr); end
    n_tests++; if (mm_din !== '0) begin n_fail++; $display("FAIL reset_mm_din: got %h want 0", mm_din); end
    n_tests++; if (fill_data !== '0) begin n_fail++; $display("FAIL reset_fill_data: got %h want 0", fill_data); end
    n_tests++; if (beat_idx !== 3'd0) begin n_fail++; $display("FAIL reset_beat_idx: got %0d want 0", beat_idx); end
    req = '0; force_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if ({grant, done, beat_valid} !== '0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0", {grant, done, beat_valid}); end
  endtask

  task automatic test_fill_cwf();
    int dc;
    logic [29:0] ea;
    lat = 3;
    reset_dut();
    do_xfer(0, 1'b0, 32'h0000_6014, dc);
    n_tests++; if (first_grant !== 4'b0001) begin n_fail++; $display("FAIL cwf_grant: got %b want 0001", first_grant); end
    n_tests++; if (n_cap !== 8) begin n_fail++; $display("FAIL cwf_beats: got %0d want 8", n_cap); end
    n_tests++; if (cap_idx[0] !== 3'd5) begin n_fail++; $display("FAIL cwf_first_idx: got %0d want 5", cap_idx[0]); end
    for (int k = 0; k < 8 && k < n_cap; k++) begin
      ea = exp_word(32'h0000_6014, 1'b0, 1'b1, k);
      n_tests++; if (cap_idx[k] !== ea[2:0]) begin n_fail++; $display("FAIL cwf_idx[%0d]: got %0d want %0d", k, cap_idx[k], ea[2:0]); end
      n_tests++; if (cap_addr[k] !== ea) begin n_fail++; $display("FAIL cwf_addr[%0d]: got %h want %h", k, cap_addr[k], ea); end
      n_tests++; if (cap_data[k] !== mem_val(ea) || cap_we[k] !== 1'b0) begin n_fail++; $display("FAIL cwf_data[%0d]: got %h/%b want %h/0", k, cap_data[k], cap_we[k], mem_val(ea)); end
    end
    n_tests++; if (dc !== 25) begin n_fail++; $display("FAIL cwf_done_cycle: got %0d want 25", dc); end
    n_tests++; if (cap_done !== 4'b0001) begin n_fail++; $display("FAIL cwf_done_vec: got %b want 0001", cap_done); end
  endtask

  task automatic test_no_cwf();
    int dc;
    int nb;
    logic [29:0] ea;
    logic [2:0]  bi [8];
    logic [29:0] ba [8];
    logic [31:0] bd [8];
    reset_dut();
    @(posedge clk); #2;
    b_req_we = 2'b00;
    b_req_addr = {32'h0, 32'h0000_6014};
    b_req = 2'b01;
    @(posedge clk);
    nb = 0; dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (b_beat_valid && nb < 8) begin
        bi[nb] = b_beat_idx; ba[nb] = b_mm_addr; bd[nb] = b_fill_data; nb++;
      end
      if (b_done != '0) begin dc = c; break; end
    end
    @(posedge clk); #2;
    b_req = 2'b00;
    n_tests++; if (nb !== 8) begin n_fail++; $display("FAIL ncwf_beats: got %0d want 8", nb); end
    for (int k = 0; k < nb; k++) begin
      ea = exp_word(32'h0000_6014, 1'b0, 1'b0, k);
      n_tests++; if (bi[k] !== 3'(k) || ba[k] !== ea) begin n_fail++; $display("FAIL ncwf_beat[%0d]: got idx %0d addr %h want idx %0d addr %h", k, bi[k], ba[k], k, ea); end
      n_tests++; if (bd[k] !== mem_val(ea)) begin n_fail++; $display("FAIL ncwf_data[%0d]: got %h want %h", k, bd[k], mem_val(ea)); end
    end
    n_tests++; if (dc !== 9) begin n_fail++; $display("FAIL ncwf_done_cycle: got %0d want 9", dc); end
  endtask

  task automatic test_writeback();
    int dc;
    lat = 2;
    reset_dut();
    do_xfer(1, 1'b1, 32'h0000_7020, dc);
    n_tests++; if (first_grant !== 4'b0010) begin n_fail++; $display("FAIL wb_grant: got %b want 0010", first_grant); end
    n_tests++; if (n_cap !== 8) begin n_fail++; $display("FAIL wb_beats: got %0d want 8", n_cap); end
    for (int k = 0; k < 8 && k < n_cap; k++) begin
      n_tests++; if (cap_addr[k] !== 30'h1C08 + 30'(k) || cap_we[k] !== 1'b1) begin n_fail++; $display("FAIL wb_addr[%0d]: got %h/%b want %h/1", k, cap_addr[k], cap_we[k], 30'h1C08 + 30'(k)); end
      n_tests++; if (cap_data[k] !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL wb_din[%0d]: got %h want %h", k, cap_data[k], 32'hA000_0000 + 32'(k)); end
    end
    n_tests++; if (dc !== 17 || cap_done !== 4'b0010) begin n_fail++; $display("FAIL wb_done: got cycle %0d vec %b want 17 0010", dc, cap_done); end
    @(negedge clk);
    n_tests++; if (done !== '0) begin n_fail++; $display("FAIL wb_done_once: got %b want 0", done); end
  endtask

  // Hold a request mask, return the sequence of grants observed.
  task automatic run_held(input logic [NP-1:0] mask, input int n, output int seq [5]);
    logic [NP-1:0] prev;
    int got;
    lat = 1;
    reset_dut();
    @(posedge clk); #2;
    req_we = '0; req = mask;
    prev = '0; got = 0;
    for (int i = 0; i < 5; i++) seq[i] = -1;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (grant != '0 && prev == '0) begin
        seq[got] = $clog2(grant);
        got++;
      end
      prev = grant;
    end
    @(posedge clk); #2;
    req = '0;
  endtask

  task automatic test_fairness();
    int seq [5];
    int last;
    int w;
    run_held(4'b0011, 4, seq);
    last = NP - 1;
    for (int i = 0; i < 4; i++) begin
      w = rr(4'b0011, last); last = w;
      n_tests++; if (seq[i] !== w) begin n_fail++; $display("FAIL fair2[%0d]: got %0d want %0d", i, seq[i], w); end
    end
    run_held(4'b1111, 5, seq);
    last = NP - 1;
    for (int i = 0; i < 5; i++) begin
      w = rr(4'b1111, last); last = w;
      n_tests++; if (seq[i] !== w) begin n_fail++; $display("FAIL fair4[%0d]: got %0d want %0d", i, seq[i], w); end
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    int dc;
    int dpulse;
    lat = 2;
    reset_dut();
    @(posedge clk); #2;
    req_we[0] = 1'b0; req_addr[0 +: AS] = 32'h0000_6014; req[0] = 1'b1;
    nb = 0;
    for (int c = 0; c < 100 && nb < 4; c++) begin
      @(negedge clk);
      if (beat_valid) nb++;
    end
    n_tests++; if (nb !== 4) begin n_fail++; $display("FAIL rmid_beats_before: got %0d want 4", nb); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if ({grant, done, mm_re, mm_we, beat_valid} !== '0) begin n_fail++; $display("FAIL rmid_ctrl: got %b want 0", {grant, done, mm_re, mm_we, beat_valid}); end
    n_tests++; if ({mm_addr, mm_din, fill_data} !== '0 || beat_idx !== 3'd0) begin n_fail++; $display("FAIL rmid_data: got %h %h %h %0d want 0", mm_addr, mm_din, fill_data, beat_idx); end
    req = '0;
    dpulse = 0;
    repeat (3) begin @(negedge clk); if (done != '0) dpulse++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done != '0) dpulse++; end
    n_tests++; if (dpulse !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", dpulse); end
    do_xfer(1, 1'b0, 32'h0000_7024, dc);
    n_tests++; if (first_grant !== 4'b0010) begin n_fail++; $display("FAIL rmid_regrant: got %b want 0010", first_grant); end
    n_tests++; if (n_cap !== 8 || cap_idx[0] !== 3'd1 || cap_addr[0] !== 30'h1C09) begin n_fail++; $display("FAIL rmid_restart: got %0d beats idx %0d addr %h want 8 1 1c09", n_cap, cap_idx[0], cap_addr[0]); end
    n_tests++; if (dc !== 17) begin n_fail++; $display("FAIL rmid_done_cycle: got %0d want 17", dc); end
  endtask

  task automatic test_stray_b2b();
    int dc;
    logic [2:0] idx0;
    lat = 1;
    reset_dut();
    @(posedge clk); #2;
    force_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idx0 = beat_idx;
    n_tests++; if ({beat_valid, grant} !== '0 || fill_data !== '0) begin n_fail++; $display("FAIL stray_idle: got bv %b grant %b fd %h want 0", beat_valid, grant, fill_data); end
    force_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (beat_idx !== idx0 || {grant, mm_re, mm_we, done} !== '0) begin n_fail++; $display("FAIL stray_state: got idx %0d ctl %b want idx %0d ctl 0", beat_idx, {grant, mm_re, mm_we, done}, idx0); end
    do_xfer(2, 1'b0, 32'h0000_4A1C, dc);
    n_tests++; if (n_cap !== 8) begin n_fail++; $display("FAIL b2b_beats: got %0d want 8", n_cap); end
    for (int k = 0; k < n_cap; k++) begin
      n_tests++; if (cap_cyc[k] !== k + 1 || cap_addr[k] !== exp_word(32'h0000_4A1C, 1'b0, 1'b1, k)) begin n_fail++; $display("FAIL b2b_beat[%0d]: got cyc %0d addr %h want cyc %0d addr %h", k, cap_cyc[k], cap_addr[k], k + 1, exp_word(32'h0000_4A1C, 1'b0, 1'b1, k)); end
    end
    n_tests++; if (dc !== 9 || cap_done !== 4'b0100) begin n_fail++; $display("FAIL b2b_done: got cycle %0d vec %b want 9 0100", dc, cap_done); end
  endtask

  // Random traffic against a transaction-level model (phase 0 idle,
  // 1 transferring, 2 completion cycle).
  task automatic test_random();
    int phase, owner, last, k, wmax;
    logic m_we;
    logic [31:0] m_addr;
    logic [29:0] ea;
    logic [NP-1:0] oh, drop;
    int waited [NP];
    reset_dut();
    stray_en = 1'b1;
    phase = 0; owner = 0; last = NP - 1; k = 0; m_we = 1'b0; m_addr = '0; oh = '0;
    for (int p = 0; p < NP; p++) waited[p] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      drop = '0;
      if (phase == 0) begin
        n_tests++; if ({grant, done, beat_valid} !== '0) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b want 0", cyc, {grant, done, beat_valid}); end
        if (req != '0) begin
          owner = rr(req, last); last = owner;
          oh = NP'(1) << owner;
          m_we = req_we[owner]; m_addr = req_addr[owner*AS +: AS];
          k = 0; phase = 1; lat = $urandom_range(1, 3);
          wmax = 0;
          for (int p = 0; p < NP; p++) begin
            if (p != owner && req[p]) waited[p]++;
            if (p == owner) waited[p] = 0;
            if (waited[p] > wmax) wmax = waited[p];
          end
          n_tests++; if (wmax > NP - 1) begin n_fail++; $display("FAIL rnd_starve[%0d]: got wait %0d want <= %0d", cyc, wmax, NP - 1); end
        end
      end else if (phase == 1) begin
        n_tests++; if ({grant, done, mm_re, mm_we} !== {oh, {NP{1'b0}}, ~m_we, m_we}) begin n_fail++; $display("FAIL rnd_xfer_ctl[%0d]: got %b want %b", cyc, {grant, done, mm_re, mm_we}, {oh, {NP{1'b0}}, ~m_we, m_we}); end
        n_tests++; if (beat_valid !== mm_valid) begin n_fail++; $display("FAIL rnd_bv[%0d]: got %b want %b", cyc, beat_valid, mm_valid); end
        if (beat_valid) begin
          ea = exp_word(m_addr, m_we, 1'b1, k);
          n_tests++; if (beat_idx !== ea[2:0] || mm_addr !== ea) begin n_fail++; $display("FAIL rnd_beat[%0d]: got idx %0d addr %h want idx %0d addr %h", cyc, beat_idx, mm_addr, ea[2:0], ea); end
          if (m_we) begin
            n_tests++; if (mm_din !== wb_val(owner, ea[2:0])) begin n_fail++; $display("FAIL rnd_din[%0d]: got %h want %h", cyc, mm_din, wb_val(owner, ea[2:0])); end
          end else begin
            n_tests++; if (fill_data !== mem_val(ea)) begin n_fail++; $display("FAIL rnd_fill[%0d]: got %h want %h", cyc, fill_data, mem_val(ea)); end
          end
          k++;
          if (k == 8) phase = 2;
        end
      end else begin
        n_tests++; if ({grant, done, mm_re, mm_we, beat_valid} !== {oh, oh, 3'b000}) begin n_fail++; $display("FAIL rnd_fin[%0d]: got %b want %b", cyc, {grant, done, mm_re, mm_we, beat_valid}, {oh, oh, 3'b000}); end
        drop = oh;
        phase = 0;
      end
      @(posedge clk); #2;
      for (int p = 0; p < NP; p++) begin
        if (drop[p]) begin
          req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(0, 5) == 0) begin
          req_we[p] = 1'($urandom_range(0, 1));
          req_addr[p*AS +: AS] = $urandom;
          req[p] = 1'b1;
          waited[p] = 0;
        end
      end
    end
    stray_en = 1'b0;
    req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0;
    b_req = '0; b_req_we = '0; b_req_addr = '0;
    test_reset();
    test_fill_cwf();
    test_no_cwf();
    test_writeback();
    test_fairness();
    test_reset_mid();
    test_stray_b2b();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
